// File: rtl/karatsuba_mul_pipe_pkg.sv
// Shared definitions for the pipelined Karatsuba multiplier.
//   - SIGNED encoding constant
//   - half-width helpers used to split an operand into low/high parts
//   - pos_sub / pos_add_shifted: non-negative subtract and shifted-add steps
//     of the recombination. They work on a fixed 64-bit carrier and callers
//     truncate the result, so operands up to 32 bits are supported.
package karatsuba_mul_pipe_pkg;

  localparam int SIGNED_ON = 1;
  localparam int PW        = 64;

  // Width of the low half (ceil) and high half (floor) of an n-bit operand.
  function automatic int half_hi(input int n);
    return (n + 1) / 2;
  endfunction

  function automatic int half_lo(input int n);
    return n / 2;
  endfunction

  // x - y where the caller guarantees x >= y.
  function automatic logic [PW-1:0] pos_sub(input logic [PW-1:0] x, input logic [PW-1:0] y);
    return x - y;
  endfunction

  // acc + (x << sh); all terms are magnitudes.
  function automatic logic [PW-1:0] pos_add_shifted(input logic [PW-1:0] acc,
                                                    input logic [PW-1:0] x,
                                                    input int            sh);
    return acc + (x << sh);
  endfunction

endpackage

// File: rtl/karatsuba_mul_pipe_mul.sv
// karatsuba_mul: combinational unsigned multiplier.
//   a_i, b_i : N_BITS-wide unsigned operands
//   c_o      : 2*N_BITS-wide product
// Widths at or below MAX_N_BITS_STANDARD_MUL use a plain multiply; wider
// operands are split once into halves and recombined Karatsuba-style
// (three half-size products instead of four).
module karatsuba_mul
  import karatsuba_mul_pipe_pkg::*;
#(
  parameter int N_BITS                  = 4,
  parameter int MAX_N_BITS_STANDARD_MUL = 4
) (
  input  logic [N_BITS-1:0]   a_i,
  input  logic [N_BITS-1:0]   b_i,
  output logic [2*N_BITS-1:0] c_o
);

  localparam int W = 2 * N_BITS;

  if (N_BITS <= MAX_N_BITS_STANDARD_MUL) begin : g_std
    assign c_o = W'(a_i) * W'(b_i);
  end else begin : g_kara
    localparam int H  = half_hi(N_BITS);
    localparam int L  = half_lo(N_BITS);
    localparam int WS = H + 1;

    logic [H-1:0]    a0, b0;
    logic [L-1:0]    a1, b1;
    logic [WS-1:0]   sa, sb;
    logic [2*H-1:0]  p0;
    logic [2*L-1:0]  p1;
    logic [2*WS-1:0] pm, mid;

    assign a0  = a_i[H-1:0];
    assign a1  = a_i[N_BITS-1:H];
    assign b0  = b_i[H-1:0];
    assign b1  = b_i[N_BITS-1:H];
    assign sa  = WS'(a0) + WS'(a1);
    assign sb  = WS'(b0) + WS'(b1);
    assign p0  = (2*H)'(a0) * (2*H)'(b0);
    assign p1  = (2*L)'(a1) * (2*L)'(b1);
    assign pm  = (2*WS)'(sa) * (2*WS)'(sb);
    // pm >= p0 + p1 always, so mid is the true cross term a0*b1 + a1*b0.
    assign mid = pm - (2*WS)'(p0) - (2*WS)'(p1);
    assign c_o = W'(p0) + (W'(mid) << H) + (W'(p1) << (2*H));
  end

endmodule

// File: rtl/karatsuba_mul_pipe.sv
// karatsuba_mul_pipe: 3-stage pipelined Karatsuba multiplier, valid/ready.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   in_valid_i / in_ready_o  : operand handshake (a_i, b_i, N_BITS each)
//   out_valid_o / out_ready_i: product handshake (c_o, 2*N_BITS)
//   busy_o                   : any stage holds a valid entry
// S1 splits operand magnitudes into halves and half-sums, S2 forms the three
// sub-products, S3 recombines and reapplies the sign. The whole pipe moves
// together on adv; bubbles are kept rather than collapsed.
module karatsuba_mul_pipe
  import karatsuba_mul_pipe_pkg::*;
#(
  parameter int N_BITS                  = 15,
  parameter int MAX_N_BITS_STANDARD_MUL = 4,
  parameter int SIGNED                  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N_BITS-1:0]   a_i,
  input  logic [N_BITS-1:0]   b_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2*N_BITS-1:0] c_o,
  output logic                busy_o
);

  localparam int N1    = half_lo(N_BITS);
  localparam int N2    = half_hi(N_BITS);
  localparam int N3    = N2 + 1;
  localparam int N_MID = N1 + N2 + 1;
  localparam int W     = 2 * N_BITS;

  logic adv;

  // Stage registers
  logic              v1_q, s1_q, v2_q, s2_q, v3_q;
  logic [N2-1:0]     a0_q, b0_q;
  logic [N1-1:0]     a1_q, b1_q;
  logic [N3-1:0]     as_q, bs_q;
  logic [2*N2-1:0]   p0_q;
  logic [2*N1-1:0]   p1_q;
  logic [2*N3-1:0]   pm_q;
  logic [W-1:0]      c_q;

  // Next-state values
  logic              s1_d;
  logic [N_BITS-1:0] mag_a_d, mag_b_d;
  logic [2*N2-1:0]   p0_d;
  logic [2*N1-1:0]   p1_d;
  logic [2*N3-1:0]   pm_d;
  logic [N_MID-1:0]  mid_d;
  logic [W-1:0]      m_d, c_d;

  assign adv = !v3_q || out_ready_i;

  // Two's-complement magnitude; -2^(N-1) maps to 2^(N-1), still fits N bits unsigned.
  assign mag_a_d = (SIGNED == SIGNED_ON && a_i[N_BITS-1]) ? (~a_i + 1'b1) : a_i;
  assign mag_b_d = (SIGNED == SIGNED_ON && b_i[N_BITS-1]) ? (~b_i + 1'b1) : b_i;
  assign s1_d    = (SIGNED == SIGNED_ON) && (a_i[N_BITS-1] ^ b_i[N_BITS-1]);

  karatsuba_mul #(.N_BITS(N2), .MAX_N_BITS_STANDARD_MUL(MAX_N_BITS_STANDARD_MUL)) u_mul_p0 (
    .a_i(a0_q), .b_i(b0_q), .c_o(p0_d)
  );
  karatsuba_mul #(.N_BITS(N1), .MAX_N_BITS_STANDARD_MUL(MAX_N_BITS_STANDARD_MUL)) u_mul_p1 (
    .a_i(a1_q), .b_i(b1_q), .c_o(p1_d)
  );
  karatsuba_mul #(.N_BITS(N3), .MAX_N_BITS_STANDARD_MUL(MAX_N_BITS_STANDARD_MUL)) u_mul_pm (
    .a_i(as_q), .b_i(bs_q), .c_o(pm_d)
  );

  // Recombination: the magnitude is below 2^(2N), so truncating to W bits is exact.
  assign mid_d = N_MID'(pos_sub(pos_sub(PW'(pm_q), PW'(p0_q)), PW'(p1_q)));
  assign m_d   = W'(pos_add_shifted(pos_add_shifted(PW'(p0_q), PW'(mid_d), N2),
                                    PW'(p1_q), 2 * N2));
  assign c_d   = s2_q ? (~m_d + 1'b1) : m_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
      s1_q <= 1'b0;
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      as_q <= '0;
      bs_q <= '0;
      v2_q <= 1'b0;
      s2_q <= 1'b0;
      p0_q <= '0;
      p1_q <= '0;
      pm_q <= '0;
      v3_q <= 1'b0;
      c_q  <= '0;
    end else if (adv) begin
      v1_q <= in_valid_i;
      s1_q <= s1_d;
      a0_q <= mag_a_d[N2-1:0];
      a1_q <= mag_a_d[N_BITS-1:N2];
      b0_q <= mag_b_d[N2-1:0];
      b1_q <= mag_b_d[N_BITS-1:N2];
      as_q <= N3'(mag_a_d[N2-1:0]) + N3'(mag_a_d[N_BITS-1:N2]);
      bs_q <= N3'(mag_b_d[N2-1:0]) + N3'(mag_b_d[N_BITS-1:N2]);
      v2_q <= v1_q;
      s2_q <= s1_q;
      p0_q <= p0_d;
      p1_q <= p1_d;
      pm_q <= pm_d;
      v3_q <= v2_q;
      c_q  <= c_d;
    end
  end

  assign in_ready_o  = adv;
  assign out_valid_o = v3_q;
  assign c_o         = c_q;
  assign busy_o      = v1_q | v2_q | v3_q;

endmodule
